// File: rtl/mdu_seq_if.sv
// Handshake and operand/result bundle for the sequential multiply/divide unit.
// The master side issues requests, and the slave side is the unit itself.
interface mdu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 op;
  logic                 ifunsigned;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Result;
  logic                 zero;
  logic                 div_by_zero;

  modport master (
    output start, op, ifunsigned, A, B, flush,
    input  busy, done, Result, zero, div_by_zero
  );

  modport slave (
    input  start, op, ifunsigned, A, B, flush,
    output busy, done, Result, zero, div_by_zero
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// It runs on operand magnitudes and applies the sign correction in a final fix-up cycle.
module mdu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_seq_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ACC_W-1:0]     acc_q;
  logic [WIDTH-1:0]     mb_q;
  logic                 op_q;
  logic                 neg_a_q;
  logic                 neg_res_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 zero_q;
  logic                 dbz_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 neg_a;
  logic                 neg_b;
  logic                 b_zero;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  always_comb begin
    neg_a  = ~bus.ifunsigned & bus.A[WIDTH-1];
    neg_b  = ~bus.ifunsigned & bus.B[WIDTH-1];
    mag_a  = neg_a ? (~bus.A + WIDTH'(1)) : bus.A;
    mag_b  = neg_b ? (~bus.B + WIDTH'(1)) : bus.B;
    b_zero = (bus.B == '0);
  end

  // Accumulator layout: {spare, high half, low half}. Multiply shifts right and
  // adds into the high half; divide shifts left and trial-subtracts from it.
  logic [WIDTH:0]       mul_sum;
  logic [ACC_W-1:0]     mul_next;
  logic [ACC_W-1:0]     div_sh;
  logic [WIDTH+1:0]     div_diff;
  logic [ACC_W-1:0]     div_next;
  logic [ACC_W-1:0]     step_next;

  always_comb begin
    mul_sum   = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? mb_q : {WIDTH{1'b0}})};
    mul_next  = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
    div_sh    = {acc_q[2*WIDTH-1:0], 1'b0};
    div_diff  = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, mb_q};
    div_next  = div_diff[WIDTH+1] ? div_sh
                                  : {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
    step_next = op_q ? div_next : mul_next;
  end

  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   fix_result;

  // Remainder follows the dividend's sign; quotient/product follow the sign XOR.
  always_comb begin
    prod = acc_q[2*WIDTH-1:0];
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (op_q) begin
      fix_result = {(neg_a_q ? -rem : rem), (neg_res_q ? -quo : quo)};
    end else begin
      fix_result = neg_res_q ? -prod : prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mb_q      <= '0;
      op_q      <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
          if (bus.start && !bus.flush) begin
            if (bus.op && b_zero) begin
              // Divide by zero short-circuits the iteration entirely.
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= {bus.A, {WIDTH{1'b1}}};
              zero_q   <= 1'b0;
              dbz_q    <= 1'b1;
            end else begin
              state_q   <= StRun;
              busy_q    <= 1'b1;
              cnt_q     <= CNT_W'(WIDTH - 1);
              acc_q     <= {{(WIDTH + 1){1'b0}}, mag_a};
              mb_q      <= mag_b;
              op_q      <= bus.op;
              neg_a_q   <= neg_a;
              neg_res_q <= neg_a ^ neg_b;
            end
          end
        end
        StRun: begin
          if (bus.flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= step_next;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
              state_q <= StFix;
            end
          end
        end
        StFix: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state_q <= StIdle;
          end else begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= fix_result;
            zero_q   <= (fix_result == '0);
            dbz_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.Result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases, random operations against an
// arithmetic reference model, handshake ordering, and the flush/reset abort paths.
module tb_mdu_seq;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    logic        z;
    logic        dz;
  } vec_t;

  task automatic model(input logic op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, output logic [63:0] r, output logic z,
                       output logic dz);
    longint sa, sb, q, rm;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    if (op && b == 32'd0) begin
      r  = {a, 32'hFFFF_FFFF};
      dz = 1'b1;
    end else if (!op) begin
      if (uns) r = ua * ub;
      else     r = sa * sb;
    end else if (uns) begin
      r = {a % b, a / b};
    end else begin
      q  = sa / sb;
      rm = sa % sb;
      r  = {rm[31:0], q[31:0]};
    end
    z = (r == 64'd0);
  endtask

  // Issues one request and waits (bounded) for done; lat counts from the accept edge.
  task automatic do_op(input logic op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output int bcnt);
    bus.start = 1'b1; bus.op = op; bus.ifunsigned = uns; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
    checks++; if (bus.Result !== 64'd0) begin errors++; $display("FAIL reset Result: got %h want 0", bus.Result); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset zero: got %b want 0", bus.zero); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset div_by_zero: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_directed();
    vec_t tbl [7];
    int lat, bcnt;
    tbl[0] = '{1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 32'd0, 32'd9, 64'd0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].op, tbl[i].uns, tbl[i].a, tbl[i].b, lat, bcnt);
      checks++; if (bus.Result !== tbl[i].r) begin errors++; $display("FAIL directed[%0d] Result: got %h want %h", i, bus.Result, tbl[i].r); end
      checks++; if (bus.zero !== tbl[i].z) begin errors++; $display("FAIL directed[%0d] zero: got %b want %b", i, bus.zero, tbl[i].z); end
      checks++; if (bus.div_by_zero !== tbl[i].dz) begin errors++; $display("FAIL directed[%0d] div_by_zero: got %b want %b", i, bus.div_by_zero, tbl[i].dz); end
      checks++; if (lat != (tbl[i].dz ? 1 : 34)) begin errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, tbl[i].dz ? 1 : 34); end
      checks++; if (bcnt != (tbl[i].dz ? 0 : 33)) begin errors++; $display("FAIL directed[%0d] busy cycles: got %0d want %0d", i, bcnt, tbl[i].dz ? 0 : 33); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL directed[%0d] done pulse width: got done=%b want 0", i, bus.done); end
    end
  endtask

  task automatic test_random();
    logic        op, uns, z, dz;
    logic [31:0] a, b;
    logic [63:0] r;
    int          lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      op  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      a   = pick();
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      model(op, uns, a, b, r, z, dz);
      do_op(op, uns, a, b, lat, bcnt);
      checks++; if (bus.Result !== r) begin errors++; $display("FAIL random[%0d] op=%b uns=%b a=%h b=%h Result: got %h want %h", i, op, uns, a, b, bus.Result, r); end
      checks++; if ({bus.zero, bus.div_by_zero} !== {z, dz}) begin errors++; $display("FAIL random[%0d] zero/dbz: got %b%b want %b%b", i, bus.zero, bus.div_by_zero, z, dz); end
      checks++; if (lat != (dz ? 1 : 34)) begin errors++; $display("FAIL random[%0d] latency: got %0d want %0d", i, lat, dz ? 1 : 34); end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_busy_start_ignored();
    int lat;
    bus.start = 1'b1; bus.op = 1'b0; bus.ifunsigned = 1'b1; bus.A = 32'd1000; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    repeat (5) begin @(posedge clk); #1; lat++; end
    bus.start = 1'b1; bus.op = 1'b1; bus.A = 32'd77; bus.B = 32'd0;
    @(posedge clk); #1; lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++; if (bus.Result !== 64'd3000) begin errors++; $display("FAIL busy_start Result: got %h want %h", bus.Result, 64'd3000); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL busy_start div_by_zero: got %b want 0", bus.div_by_zero); end
    checks++; if (lat != 34) begin errors++; $display("FAIL busy_start latency: got %0d want 34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    do_op(1'b0, 1'b1, 32'd6, 32'd7, lat, bcnt);
    checks++; if (bus.Result !== 64'd42) begin errors++; $display("FAIL b2b first Result: got %h want %h", bus.Result, 64'd42); end
    // Second request is presented during the done cycle of the first.
    do_op(1'b1, 1'b1, 32'd100, 32'd7, lat, bcnt);
    checks++; if (bus.Result !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b second Result: got %h want %h", bus.Result, {32'd2, 32'd14}); end
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b second latency: got %0d want 34", lat); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL b2b second busy cycles: got %0d want 33", bcnt); end
  endtask

  task automatic test_flush();
    logic [63:0] prev;
    int          lat, bcnt, seen;
    prev = {32'd2, 32'd14};
    // Flush in RUN cycle 10.
    bus.start = 1'b1; bus.op = 1'b0; bus.ifunsigned = 1'b1; bus.A = 32'd5; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_run busy: got %b want 0", bus.busy); end
    seen = 0;
    repeat (40) begin if (bus.done === 1'b1) seen++; @(posedge clk); #1; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_run done pulses: got %0d want 0", seen); end
    checks++; if (bus.Result !== prev) begin errors++; $display("FAIL flush_run Result: got %h want %h", bus.Result, prev); end
    // Flush in the FIX cycle.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (32) begin @(posedge clk); #1; end
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL flush_fix pre busy/done: got %b want 10", {bus.busy, bus.done}); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    seen = 0;
    repeat (5) begin if (bus.done === 1'b1 || bus.busy === 1'b1) seen++; @(posedge clk); #1; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_fix busy/done cycles: got %0d want 0", seen); end
    checks++; if (bus.Result !== prev) begin errors++; $display("FAIL flush_fix Result: got %h want %h", bus.Result, prev); end
    // Flush together with start in IDLE drops the start.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 1'b1; bus.A = 32'd9; bus.B = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL flush_start busy/done: got %b want 00", {bus.busy, bus.done}); end
    checks++; if (bus.Result !== prev) begin errors++; $display("FAIL flush_start Result: got %h want %h", bus.Result, prev); end
    // Flush plus start in the DONE cycle: back to IDLE, start dropped.
    do_op(1'b0, 1'b1, 32'd3, 32'd4, lat, bcnt);
    checks++; if (bus.Result !== 64'd12) begin errors++; $display("FAIL flush_done Result: got %h want %h", bus.Result, 64'd12); end
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 1'b0; bus.A = 32'd8; bus.B = 32'd8;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL flush_done busy/done: got %b want 00", {bus.busy, bus.done}); end
    checks++; if (bus.Result !== 64'd12) begin errors++; $display("FAIL flush_done kept Result: got %h want %h", bus.Result, 64'd12); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    bus.start = 1'b1; bus.op = 1'b0; bus.ifunsigned = 1'b1; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.zero, bus.div_by_zero} !== 4'b0000) begin errors++; $display("FAIL rst_mid flags: got %b want 0000", {bus.busy, bus.done, bus.zero, bus.div_by_zero}); end
    checks++; if (bus.Result !== 64'd0) begin errors++; $display("FAIL rst_mid Result: got %h want 0", bus.Result); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid post-release busy/done cycles: got %0d want 0", seen); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.ifunsigned = 1'b0;
    bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_busy_start_ignored();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
